// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and elaboration helpers
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Smallest r with 2**r >= value; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pix_en_div.sv
// rtl/pix_en_div.sv - divides clk into a registered one-clk pixel-enable strobe
module pix_en_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en
);

  localparam int DIV_W = (clog2(CLK_DIV) < 1) ? 1 : clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
    $error("pix_en_div: CLK_DIV must be in 1..16");
  end

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      pix_en <= (div == DIV_LAST);
      div    <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with strobes and frame count
// Optional macro VGA_TIMING_PREFETCH_EN adds NextX/NextY/nextInDisplay lookahead outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 10,
  parameter int CLK_DIV  = 2,
  parameter int FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_en,
  output logic               vga_h_sync,
  output logic               vga_v_sync,
  output logic               inDisplayArea,
  output logic [CNT_W-1:0]   CounterX,
  output logic [CNT_W-1:0]   CounterY,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic [CNT_W-1:0]   NextX,
  output logic [CNT_W-1:0]   NextY,
  output logic               nextInDisplay
`endif
);

  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("vga_timing_gen: active, porch and sync parameters must be non-zero");
  end
  if (clog2(H_TOTAL) > CNT_W || clog2(V_TOTAL) > CNT_W) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 or V_TOTAL-1");
  end
  if (FRAME_W < 1) begin : g_bad_frame_w
    $error("vga_timing_gen: FRAME_W must be at least 1");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_LVL = (HS_POL != 0);
  localparam logic VS_LVL = (VS_POL != 0);

  pix_en_div #(.CLK_DIV(CLK_DIV)) u_pix_en_div (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en)
  );

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] next_x;
  logic [CNT_W-1:0] next_y;

  // Coordinates after the next pix_en; drives both the counters and the lookahead ports.
  always_comb begin
    h_wrap = (CounterX == H_LAST);
    v_wrap = (CounterY == V_LAST);
    next_x = h_wrap ? '0 : CounterX + CNT_W'(1);
    next_y = CounterY;
    if (h_wrap) next_y = v_wrap ? '0 : CounterY + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      CounterX    <= '0;
      CounterY    <= '0;
      frame_count <= '0;
    end else if (pix_en) begin
      CounterX <= next_x;
      CounterY <= next_y;
      if (h_wrap && v_wrap) frame_count <= frame_count + FRAME_W'(1);
    end
  end

  assign vga_h_sync    = (CounterX >= HS_BEGIN && CounterX < HS_END) ? HS_LVL : ~HS_LVL;
  assign vga_v_sync    = (CounterY >= VS_BEGIN && CounterY < VS_END) ? VS_LVL : ~VS_LVL;
  assign inDisplayArea = (CounterX < H_ACT) && (CounterY < V_ACT);
  assign line_start    = pix_en && (CounterX == '0);
  assign frame_start   = line_start && (CounterY == '0);

`ifdef VGA_TIMING_PREFETCH_EN
  assign NextX         = next_x;
  assign NextY         = next_y;
  assign nextInDisplay = (next_x < H_ACT) && (next_y < V_ACT);
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench: three parameter sets against an arithmetic raster model
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic chk_on = 1'b0;
  int   checks = 0, errors = 0;
  int   ka = 0, kb = 0, kc = 0;

  logic       a_pe, a_hs, a_vs, a_de, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [7:0] a_fc;
  logic       b_pe, b_hs, b_vs, b_de, b_ls, b_fs;
  logic [3:0] b_x, b_y;
  logic [7:0] b_fc;
  logic       c_pe, c_hs, c_vs, c_de, c_ls, c_fs;
  logic [4:0] c_x, c_y;
  logic [3:0] c_fc;
`ifdef VGA_TIMING_PREFETCH_EN
  logic [9:0] a_nx, a_ny;
  logic [3:0] b_nx, b_ny;
  logic [4:0] c_nx, c_ny;
  logic       a_nde, b_nde, c_nde;
`endif

  vga_timing_gen u_a (
    .clk(clk), .reset(rst_a), .pix_en(a_pe), .vga_h_sync(a_hs), .vga_v_sync(a_vs),
    .inDisplayArea(a_de), .CounterX(a_x), .CounterY(a_y), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc)
`ifdef VGA_TIMING_PREFETCH_EN
    , .NextX(a_nx), .NextY(a_ny), .nextInDisplay(a_nde)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CNT_W(4), .CLK_DIV(1), .FRAME_W(8)
  ) u_b (
    .clk(clk), .reset(rst_b), .pix_en(b_pe), .vga_h_sync(b_hs), .vga_v_sync(b_vs),
    .inDisplayArea(b_de), .CounterX(b_x), .CounterY(b_y), .line_start(b_ls),
    .frame_start(b_fs), .frame_count(b_fc)
`ifdef VGA_TIMING_PREFETCH_EN
    , .NextX(b_nx), .NextY(b_ny), .nextInDisplay(b_nde)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1), .VS_POL(1), .CNT_W(5), .CLK_DIV(3), .FRAME_W(4)
  ) u_c (
    .clk(clk), .reset(rst_c), .pix_en(c_pe), .vga_h_sync(c_hs), .vga_v_sync(c_vs),
    .inDisplayArea(c_de), .CounterX(c_x), .CounterY(c_y), .line_start(c_ls),
    .frame_start(c_fs), .frame_count(c_fc)
`ifdef VGA_TIMING_PREFETCH_EN
    , .NextX(c_nx), .NextY(c_ny), .nextInDisplay(c_nde)
`endif
  );

  // k = clk edges since reset was last sampled; pixels consumed = floor((k-1)/div).
  function automatic logic [63:0] model(input int k, input int ha, input int hf, input int hs,
                                        input int hb, input int va, input int vf, input int vs,
                                        input int vb, input int hp, input int vp, input int d,
                                        input int fw, input int ahead);
    int ht, vt, n, x, y, f;
    logic pe, hsy, vsy, de, ls, fs;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    n   = ((k == 0) ? 0 : (k - 1) / d) + ahead;
    x   = n % ht;
    y   = (n / ht) % vt;
    f   = (n / (ht * vt)) % (1 << fw);
    pe  = (k >= 1) && (k % d == 0);
    hsy = (x >= ha + hf && x < ha + hf + hs) ? (hp != 0) : (hp == 0);
    vsy = (y >= va + vf && y < va + vf + vs) ? (vp != 0) : (vp == 0);
    de  = (x < ha) && (y < va);
    ls  = pe && (x == 0);
    fs  = ls && (y == 0);
    return {16'(x), 16'(y), 16'(f), 10'd0, pe, hsy, vsy, de, ls, fs};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    ka <= rst_a ? 0 : ka + 1;
    kb <= rst_b ? 0 : kb + 1;
    kc <= rst_c ? 0 : kc + 1;
  end

  always @(negedge clk) begin
    logic [63:0] ea, eb, ec;
    if (chk_on) begin
      ea = model(ka, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 8, 0);
      eb = model(kb, 4, 1, 2, 1, 3, 1, 1, 1, 0, 0, 1, 8, 0);
      ec = model(kc, 10, 2, 3, 2, 6, 1, 2, 2, 1, 1, 3, 4, 0);
      chk("a_outputs", {16'(a_x), 16'(a_y), 16'(a_fc), 10'd0, a_pe, a_hs, a_vs, a_de, a_ls, a_fs}, ea);
      chk("b_outputs", {16'(b_x), 16'(b_y), 16'(b_fc), 10'd0, b_pe, b_hs, b_vs, b_de, b_ls, b_fs}, eb);
      chk("c_outputs", {16'(c_x), 16'(c_y), 16'(c_fc), 10'd0, c_pe, c_hs, c_vs, c_de, c_ls, c_fs}, ec);
`ifdef VGA_TIMING_PREFETCH_EN
      ea = model(ka, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 8, 1);
      eb = model(kb, 4, 1, 2, 1, 3, 1, 1, 1, 0, 0, 1, 8, 1);
      ec = model(kc, 10, 2, 3, 2, 6, 1, 2, 2, 1, 1, 3, 4, 1);
      chk("a_next", {16'(a_nx), 16'(a_ny), 31'd0, a_nde}, {ea[63:32], 31'd0, ea[2]});
      chk("b_next", {16'(b_nx), 16'(b_ny), 31'd0, b_nde}, {eb[63:32], 31'd0, eb[2]});
      chk("c_next", {16'(c_nx), 16'(c_ny), 31'd0, c_nde}, {ec[63:32], 31'd0, ec[2]});
`endif
    end
  end

  task automatic at(input int t);
    while (ka < t) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("a_rst_x", 64'(a_x), 64'd0);
    chk("a_rst_hs", 64'(a_hs), 64'd1);
    chk("a_rst_de", 64'(a_de), 64'd1);
    chk("a_rst_pe", 64'(a_pe), 64'd0);
    chk("c_rst_syncs", {62'd0, c_hs, c_vs}, 64'd0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    at(1);     chk("b_first_fs", {62'd0, b_pe, b_fs}, 64'd3);
    at(2);     chk("a_first_fs", {61'd0, a_pe, a_ls, a_fs}, 64'd7);
    at(9);     chk("b_line1", {59'd0, b_ls, b_y}, 64'h11);
`ifdef VGA_TIMING_PREFETCH_EN
    at(48);    chk("b_next_wrap", {56'd0, b_nx, b_ny}, 64'd0);
               chk("b_next_de", 64'(b_nde), 64'd1);
`endif
    at(49);    chk("b_fc_1", {55'd0, b_fs, b_fc}, 64'h101);
    at(1279);  chk("a_x639_de", {53'd0, a_de, a_x}, {53'd0, 1'b1, 10'd639});
`ifdef VGA_TIMING_PREFETCH_EN
               chk("a_next_640", {53'd0, a_nde, a_nx}, {53'd0, 1'b0, 10'd640});
`endif
    at(1281);  chk("a_x640_de", {53'd0, a_de, a_x}, {53'd0, 1'b0, 10'd640});
    at(1311);  chk("a_hs_655", {53'd0, a_hs, a_x}, {53'd0, 1'b1, 10'd655});
    at(1313);  chk("a_hs_656", {53'd0, a_hs, a_x}, {53'd0, 1'b0, 10'd656});
    at(1503);  chk("a_hs_751", {53'd0, a_hs, a_x}, {53'd0, 1'b0, 10'd751});
    at(1505);  chk("a_hs_752", {53'd0, a_hs, a_x}, {53'd0, 1'b1, 10'd752});
    at(1601);  chk("a_line1", {44'd0, a_x, a_y}, {44'd0, 10'd0, 10'd1});
    at(12241); chk("b_fc_255", {55'd0, b_fs, b_fc}, 64'h1FF);
    at(12288); chk("b_last_px", {48'd0, b_x, b_y, b_fc}, {48'd0, 4'd7, 4'd5, 8'd255});
    at(12289); chk("b_fc_wrap", {55'd0, b_fs, b_fc}, 64'h100);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 1200)) @(negedge clk);
      rst_c = 1'b1;
      if (i % 5 == 0) rst_a = 1'b1;
      @(negedge clk);
      chk("c_midframe_rst", {48'd0, c_x, c_y, c_fc, c_pe, c_hs}, 64'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rst_c = 1'b0;
      rst_a = 1'b0;
    end
    repeat (50) @(negedge clk);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
